// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer: next-PC source
// encoding, sequencer state encoding and the default reset/exception vectors.
// ---------------------------------------------------------------------------
package pc_pkg;

  // Next-PC source select; codes 5..7 are reserved and flagged as illegal.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_REG    = 3'd3,
    SEL_ERET   = 3'd4
  } pc_sel_e;

  // RUN: normal execution. EXL: inside the exception handler.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXL = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC formation for the PC sequencer.
//
// Ports:
//   pc          in  WIDTH  current PC
//   sel         in  3      next-PC source select (pc_sel_e encoding)
//   br_tgt      in  WIDTH  branch target
//   jidx        in  26     J-type instruction index
//   reg_tgt     in  WIDTH  register target
//   next_pc     out WIDTH  candidate next PC for SEQ/BRANCH/JUMP/REG
//   pc_plus4    out WIDTH  pc + 4 (modulo 2^WIDTH)
//   align_fault out 1      BRANCH/REG target misaligned (PC_ALIGN_CHECK_EN only)
//   bad_target  out WIDTH  offending target       (PC_ALIGN_CHECK_EN only)
//
// Configuration macro: PC_ALIGN_CHECK_EN adds the misalignment detector.
// ERET and reserved codes are resolved by the top level; for those codes
// next_pc simply carries pc + 4 and is ignored.
// WIDTH must be at least 32 so the jump region bits [WIDTH-1:28] exist.
// ---------------------------------------------------------------------------
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] br_tgt,
  input  logic [25:0]      jidx,
  input  logic [WIDTH-1:0] reg_tgt,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             align_fault,
  output logic [WIDTH-1:0] bad_target
`endif
);

  // Clearing the low two bits keeps every loaded target word aligned. With
  // the alignment check enabled a misaligned target never gets loaded, so the
  // mask only matters in the default build.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_SEQ:    next_pc = pc_plus4;
      SEL_BRANCH: next_pc = br_tgt & ALIGN_MASK;
      // The jump stays in the 256 MB region of the delay-slot address.
      SEL_JUMP:   next_pc = {pc_plus4[WIDTH-1:28], jidx, 2'b00};
      SEL_REG:    next_pc = reg_tgt & ALIGN_MASK;
      default:    next_pc = pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    align_fault = 1'b0;
    bad_target  = '0;
    if ((sel == SEL_BRANCH) && (br_tgt[1:0] != 2'b00)) begin
      align_fault = 1'b1;
      bad_target  = br_tgt;
    end else if ((sel == SEL_REG) && (reg_tgt[1:0] != 2'b00)) begin
      align_fault = 1'b1;
      bad_target  = reg_tgt;
    end
  end
`endif

endmodule

// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq
// Program-counter sequencer for the multicycle MIPS datapath. Holds the PC,
// the exception return address (EPC) and the one-level exception state.
//
// Ports:
//   clk         in  1      clock, rising edge
//   rst         in  1      asynchronous reset, active low
//   en          in  1      PC write enable for sel_i driven updates
//   sel_i       in  3      next-PC source (SEQ/BRANCH/JUMP/REG/ERET)
//   br_tgt_i    in  WIDTH  branch target
//   jidx_i      in  26     J-type instruction index
//   reg_tgt_i   in  WIDTH  register target (jr/jalr)
//   exc_req_i   in  1      exception request, independent of en
//   pc_o        out WIDTH  current PC
//   pc_plus4_o  out WIDTH  pc_o + 4
//   epc_o       out WIDTH  exception return address
//   exl_o       out 1      high while in the exception handler
//   illegal_o   out 1      one-cycle pulse on ERET outside EXL or reserved sel
//   badaddr_o   out WIDTH  last misaligned target (PC_ALIGN_CHECK_EN only)
//
// Configuration macro: PC_ALIGN_CHECK_EN turns misaligned BRANCH/REG targets
// into exceptions and adds badaddr_o. WIDTH must be at least 32.
// ---------------------------------------------------------------------------
module pc_seq
  import pc_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] br_tgt_i,
  input  logic [25:0]      jidx_i,
  input  logic [WIDTH-1:0] reg_tgt_i,
  input  logic             exc_req_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             exl_o,
  output logic             illegal_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic [WIDTH-1:0] badaddr_o
`endif
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

  pc_state_e        state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic             illegal;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] pc_plus4;

`ifdef PC_ALIGN_CHECK_EN
  logic             align_fault;
  logic [WIDTH-1:0] bad_target;
  logic [WIDTH-1:0] badaddr;
`else
  localparam logic  align_fault = 1'b0;
`endif

  pc_next_mux #(
    .WIDTH (WIDTH)
  ) u_next_mux (
    .pc          (pc),
    .sel         (sel_i),
    .br_tgt      (br_tgt_i),
    .jidx        (jidx_i),
    .reg_tgt     (reg_tgt_i),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_fault (align_fault),
    .bad_target  (bad_target)
`endif
  );

  // Sequencer FSM. An exception (external request, or a misaligned target
  // when the check is built in) beats any sel_i update. EPC is captured only
  // on entry from RUN so a nested exception keeps the original return
  // address. illegal defaults low so it is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      pc      <= RST_PC;
      epc     <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (exc_req_i || (en && align_fault)) begin
        pc <= EXC_PC;
        if (state == ST_RUN) begin
          epc   <= pc;
          state <= ST_EXL;
        end
      end else if (en) begin
        case (sel_i)
          SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_REG: begin
            pc <= next_pc;
          end
          SEL_ERET: begin
            if (state == ST_EXL) begin
              pc    <= epc;
              state <= ST_RUN;
            end else begin
              illegal <= 1'b1;
            end
          end
          default: begin
            illegal <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // The faulting target is recorded even when an external request lands in
  // the same cycle, since the handler may still want to inspect it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badaddr <= '0;
    end else if (en && align_fault) begin
      badaddr <= bad_target;
    end
  end

  assign badaddr_o = badaddr;
`endif

  assign pc_o       = pc;
  assign pc_plus4_o = pc_plus4;
  assign epc_o      = epc;
  assign exl_o      = (state == ST_EXL);
  assign illegal_o  = illegal;

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the multicycle MIPS datapath. It holds the PC and forms the next PC internally from a source select: sequential, branch, jump, register or exception return. It also vectors to an exception handler, capturing the return address in an EPC register guarded by a one-level exception-level (EXL) state. It replaces the plain enable-gated PC register in the datapath; the control FSM drives `en`, `sel_i` and `exc_req_i`.

## Interface
- `WIDTH`, 32, PC/address width; must be ≥ 32.
- `RESET_VECTOR`, 32'h0040_0000, PC value after reset, zero-extended to WIDTH.
- `EXC_VECTOR`, 32'h8000_0180, exception handler entry, zero-extended to WIDTH.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  PC write enable (PCWrite); gates `sel_i` updates only.
- `sel_i`  in  3  next-PC source (encoding in Structure).
- `br_tgt_i`  in  WIDTH  branch target from ALU.
- `jidx_i`  in  26  J-type instruction index.
- `reg_tgt_i`  in  WIDTH  register target (jr/jalr).
- `exc_req_i`  in  1  exception request; acts regardless of `en`.
- `pc_o`  out  WIDTH  current PC.
- `pc_plus4_o`  out  WIDTH  pc_o + 4, combinational.
- `epc_o`  out  WIDTH  exception return address.
- `exl_o`  out  1  1 while in handler (state EXL).
- `illegal_o`  out  1  one-cycle pulse: ERET outside EXL, or reserved `sel_i` with `en`.

## Operation
- States: RUN, EXL. Reset → RUN, `pc_o`=RESET_VECTOR, `epc_o`=0, `exl_o`=0, `illegal_o`=0.
- Priority per cycle: `exc_req_i` > (`en` && `sel_i`) > hold.
- `exc_req_i`=1: PC←EXC_VECTOR. In RUN: EPC←`pc_o`, state→EXL. In EXL: EPC unchanged (nested exception keeps the original return address), state stays EXL.
- `en`=1, `exc_req_i`=0:
  - SEQ: PC←`pc_o`+4.
  - BRANCH: PC←`br_tgt_i`.
  - JUMP: PC←{(`pc_o`+4)[WIDTH-1:28], `jidx_i`, 2'b00}.
  - REG: PC←`reg_tgt_i`.
  - ERET in EXL: PC←`epc_o`, state→RUN.
  - ERET in RUN: PC holds, `illegal_o` pulses.
  - Reserved codes: PC holds, `illegal_o` pulses.
- `en`=0, no exception: PC, EPC and state hold.
- Arithmetic is modulo 2^WIDTH; `pc_o`+4 wraps from all-ones−3 to 0 silently.

## Timing
- One-cycle latency: the selected source appears on `pc_o` after the next rising edge.
- `pc_plus4_o` and the next-PC mux are combinational from current inputs; no input registering.
- `illegal_o` is registered and high for exactly the cycle after the offending edge.
- Reset asserted mid-operation immediately forces all outputs to reset values, regardless of clock. Deassertion is synchronised externally.
- `exc_req_i` coincident with ERET in EXL: the exception wins; PC←EXC_VECTOR, EPC unchanged, state stays EXL.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A BRANCH or REG target with bits [1:0]≠0 is not loaded.
  - It is treated as an exception: PC←EXC_VECTOR, EPC/state follow the `exc_req_i` rules.
  - Added port `badaddr_o` (WIDTH) latches the offending target. Reset value 0; it holds otherwise.
- Undefined: no check; target bits [1:0] are forced to 0 on load, and `badaddr_o` is absent.

## Structure
- Package `pc_pkg`:
  - `sel_i` encoding: SEQ=0, BRANCH=1, JUMP=2, REG=3, ERET=4, 5–7 reserved.
  - State enum {RUN, EXL}.
  - Default vector constants.
- Sub-module `pc_next_mux`: combinational next-PC and pc+4 formation, plus the alignment-fault flag. The top level holds PC, EPC, state and `illegal_o`.

## Test plan
- Reset low → `pc_o`=0x0040_0000, `epc_o`=0, `exl_o`=0. Release, then 3× `en`+SEQ → 0x0040_000C.
- At PC 0x0040_0010, JUMP with `jidx_i`=0x0100040 → 0x0040_0100. `en`=0 with BRANCH → PC holds.
- At PC 0x0040_0020, `exc_req_i` → PC=0x8000_0180, EPC=0x0040_0020, `exl_o`=1. Second `exc_req_i` → EPC still 0x0040_0020. ERET → PC=0x0040_0020, `exl_o`=0.
- ERET in RUN → PC unchanged and `illegal_o` high one cycle. `sel_i`=6 with `en` → same response.
- PC=0xFFFF_FFFC, SEQ → 0x0000_0000. Reset pulsed between clock edges mid-run → immediate 0x0040_0000.
- With `PC_ALIGN_CHECK_EN`, REG target 0x0040_0102 → PC=0x8000_0180, `badaddr_o`=0x0040_0102. Without it, the same stimulus → PC=0x0040_0100.
